// File: rtl/ib_vnu3_f0_lut_loader.sv
// -----------------------------------------------------------------------------
// ib_vnu3_f0_lut_loader
//
// Write-side feeder for the VNU3 F0 stage's shared IB-VNU LUT RAM. A load
// rewrites one multi-frame half of the RAM (PAGE_NUM entries) from a stream of
// LUT entries while the other half keeps serving reads.
//
// Handshake: a beat transfers in a cycle where lut_valid_in && lut_ready_out
// are both high at the rising edge of write_clk. The producer may hold or drop
// lut_valid_in freely; lut_ready_out is high only while the FSM is in LOAD.
//
// Optional feature: define IB_LUT_LOADER_CHECKSUM_EN to add the lut_checksum
// output (XOR of every entry written in the current load).
//
// Ports:
//   write_clk                  clock
//   rstn                       asynchronous active-low reset
//   load_start / load_frame    start a load into frame half load_frame
//   load_abort                 terminate an active load
//   lut_data_in/lut_valid_in   entry stream in
//   lut_ready_out              loader accepts a beat this cycle
//   page_addr_ram_replicate_0/1, ram_write_data_0/1, ib_ram_we
//                              registered RAM write port (both replicates)
//   loader_busy, load_done     status; load_done pulses with the final write
//   loader_err                 sticky protocol error (load_start while busy)
//   lut_checksum               (optional) XOR of entries written this load
//   dbg_state                  current FSM state for observation
// -----------------------------------------------------------------------------
module ib_vnu3_f0_lut_loader #(
   parameter int QUAN_SIZE     = 3,
   parameter int ENTRY_ADDR    = 5,
   parameter int LUT_PORT_SIZE = 3,
   parameter int BANK_NUM      = 1
) (
   input  logic                              write_clk,
   input  logic                              rstn,
   input  logic                              load_start,
   input  logic                              load_frame,
   input  logic                              load_abort,
   input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] lut_data_in,
   input  logic                              lut_valid_in,
   output logic                              lut_ready_out,
   output logic [ENTRY_ADDR-1:0]             page_addr_ram_replicate_0,
   output logic [ENTRY_ADDR-1:0]             page_addr_ram_replicate_1,
   output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_0,
   output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
   output logic                              ib_ram_we,
   output logic                              loader_busy,
   output logic                              load_done,
   output logic                              loader_err,
`ifdef IB_LUT_LOADER_CHECKSUM_EN
   output logic [LUT_PORT_SIZE*BANK_NUM-1:0] lut_checksum,
`endif
   output logic [1:0]                        dbg_state
);

   localparam int DW       = LUT_PORT_SIZE * BANK_NUM;
   localparam int CW       = ENTRY_ADDR - 1;
   localparam int PAGE_NUM = 2 ** CW;
   localparam logic [CW-1:0] LAST_PAGE = CW'(PAGE_NUM - 1);

   // Message width does not shape the write path; it only has to be sane.
   if (QUAN_SIZE < 1 || LUT_PORT_SIZE < 1 || BANK_NUM < 1 || ENTRY_ADDR < 2) begin : g_param_check
      $error("ib_vnu3_f0_lut_loader: illegal parameter set");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              frame_q, frame_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [ENTRY_ADDR-1:0] addr_q, addr_d;
   logic [DW-1:0]     data_q, data_d;
   logic              ready_q, busy_q, done_q;
   logic [DW-1:0]     chk_q, chk_d;
   logic              accept;

   // ready_q mirrors state_q == S_LOAD, so this is the handshake condition.
   assign accept = lut_valid_in && ready_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      err_d   = err_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      chk_d   = chk_q;
      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               frame_d = load_frame;
               cnt_d   = '0;
               chk_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (load_start) err_d = 1'b1;
            if (load_abort) begin
               // Abort wins over a same-cycle beat: the beat is dropped unwritten.
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (accept) begin
               we_d   = 1'b1;
               addr_d = {frame_q, cnt_q};
               data_d = lut_data_in;
               chk_d  = chk_q ^ lut_data_in;
               if (cnt_q == LAST_PAGE) begin
                  state_d = S_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            if (load_start) err_d = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         frame_q <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         chk_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         chk_q   <= chk_d;
         // Status outputs are registered decodes of the next state.
         ready_q <= (state_d == S_LOAD);
         busy_q  <= (state_d == S_LOAD);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign lut_ready_out             = ready_q;
   assign loader_busy               = busy_q;
   assign load_done                 = done_q;
   assign loader_err                = err_q;
   assign ib_ram_we                 = we_q;
   assign page_addr_ram_replicate_0 = addr_q;
   assign page_addr_ram_replicate_1 = addr_q;
   assign ram_write_data_0          = data_q;
   assign ram_write_data_1          = data_q;
   assign dbg_state                 = state_q;

`ifdef IB_LUT_LOADER_CHECKSUM_EN
   assign lut_checksum = chk_q;
`else
   // Without the checksum output the accumulator has no observer and is
   // optimised away; this keeps it referenced for lint.
   logic unused_chk;
   assign unused_chk = ^chk_q;
`endif

endmodule

// File: tb/tb_ib_vnu3_f0_lut_loader.sv
module tb_ib_vnu3_f0_lut_loader;

   localparam int DW = 3;
   localparam int AW = 5;

   logic          write_clk = 1'b0;
   logic          rstn = 1'b0;
   logic          load_start = 1'b0;
   logic          load_frame = 1'b0;
   logic          load_abort = 1'b0;
   logic [DW-1:0] lut_data_in = '0;
   logic          lut_valid_in = 1'b0;
   logic          lut_ready_out;
   logic [AW-1:0] page_addr_ram_replicate_0, page_addr_ram_replicate_1;
   logic [DW-1:0] ram_write_data_0, ram_write_data_1;
   logic          ib_ram_we, loader_busy, load_done, loader_err;
   logic [1:0]    dbg_state;
`ifdef IB_LUT_LOADER_CHECKSUM_EN
   logic [DW-1:0] lut_checksum;
`endif

   ib_vnu3_f0_lut_loader dut (
      .write_clk                 (write_clk),
      .rstn                      (rstn),
      .load_start                (load_start),
      .load_frame                (load_frame),
      .load_abort                (load_abort),
      .lut_data_in               (lut_data_in),
      .lut_valid_in              (lut_valid_in),
      .lut_ready_out             (lut_ready_out),
      .page_addr_ram_replicate_0 (page_addr_ram_replicate_0),
      .page_addr_ram_replicate_1 (page_addr_ram_replicate_1),
      .ram_write_data_0          (ram_write_data_0),
      .ram_write_data_1          (ram_write_data_1),
      .ib_ram_we                 (ib_ram_we),
      .loader_busy               (loader_busy),
      .load_done                 (load_done),
      .loader_err                (loader_err),
`ifdef IB_LUT_LOADER_CHECKSUM_EN
      .lut_checksum              (lut_checksum),
`endif
      .dbg_state                 (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 write_clk = ~write_clk;

   // ---------------- reference model state ----------------
   // Record: [11] load_done, [10:6] address, [5:3] data, [2:0] running XOR
   logic [11:0] exp_q[$];
   logic [11:0] rec;
   bit          m_busy = 1'b0;
   bit          m_err  = 1'b0;
   logic        m_frame = 1'b0;
   int          m_page = 0;
   logic [DW-1:0] m_xor = '0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge write_clk);
      #1;
   endtask

   task automatic idle(input int n);
      lut_valid_in = 1'b0;
      repeat (n) step();
   endtask

   // Start a load from the idle state.
   task automatic start_load(input logic f);
      load_start = 1'b1;
      load_frame = f;
      step();
      load_start = 1'b0;
      m_busy  = 1'b1;
      m_frame = f;
      m_page  = 0;
      m_xor   = '0;
   endtask

   // One beat while loading; abort=1 drops it and ends the load.
   task automatic beat(input logic [DW-1:0] d, input bit abort);
      lut_valid_in = 1'b1;
      lut_data_in  = d;
      load_abort   = abort;
      step();
      lut_valid_in = 1'b0;
      load_abort   = 1'b0;
      if (abort) begin
         m_busy = 1'b0;
         m_page = 0;
      end else begin
         m_xor = m_xor ^ d;
         exp_q.push_back({1'(m_page == 15), m_frame, 4'(m_page), d, m_xor});
         if (m_page == 15) m_busy = 1'b0;
         m_page++;
      end
   endtask

   // load_start while busy: ignored except for the sticky error.
   task automatic bad_start(input bit with_abort);
      load_start = 1'b1;
      load_frame = ~m_frame;
      load_abort = with_abort;
      lut_valid_in = with_abort;
      lut_data_in  = 3'b111;
      step();
      load_start = 1'b0;
      load_abort = 1'b0;
      lut_valid_in = 1'b0;
      m_err = 1'b1;
      if (with_abort) begin
         m_busy = 1'b0;
         m_page = 0;
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge write_clk) begin
      if (ib_ram_we) begin
         if (exp_q.size() == 0) begin
            chk("spurious_we", 32'(ib_ram_we), 32'd0);
         end else begin
            rec = exp_q.pop_front();
            chk("addr0", 32'(page_addr_ram_replicate_0), 32'(rec[10:6]));
            chk("addr1", 32'(page_addr_ram_replicate_1), 32'(rec[10:6]));
            chk("data0", 32'(ram_write_data_0), 32'(rec[5:3]));
            chk("data1", 32'(ram_write_data_1), 32'(rec[5:3]));
            chk("load_done", 32'(load_done), 32'(rec[11]));
`ifdef IB_LUT_LOADER_CHECKSUM_EN
            if (rec[11]) chk("checksum", 32'(lut_checksum), 32'(rec[2:0]));
`endif
         end
      end else begin
         chk("done_without_we", 32'(load_done), 32'd0);
      end
      chk("busy", 32'(loader_busy), 32'(m_busy));
      chk("ready", 32'(lut_ready_out), 32'(m_busy));
      chk("err", 32'(loader_err), 32'(m_err));
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset with stray valid and no start.
      lut_valid_in = 1'b1;
      lut_data_in  = 3'b110;
      repeat (3) @(posedge write_clk);
      #1;
      chk("rst_addr0", 32'(page_addr_ram_replicate_0), 32'd0);
      chk("rst_addr1", 32'(page_addr_ram_replicate_1), 32'd0);
      chk("rst_data0", 32'(ram_write_data_0), 32'd0);
      chk("rst_data1", 32'(ram_write_data_1), 32'd0);
      chk("rst_we", 32'(ib_ram_we), 32'd0);
`ifdef IB_LUT_LOADER_CHECKSUM_EN
      chk("rst_checksum", 32'(lut_checksum), 32'd0);
`endif
      rstn = 1'b1;
      repeat (4) step();          // valid still high, no start: no writes
      idle(1);

      // Full load into frame 1, data = page mod 8, back-to-back.
      start_load(1'b1);
      for (int p = 0; p < 16; p++) beat(3'(p % 8), 1'b0);
      idle(2);

      // Throttled load into frame 0, valid every other cycle.
      start_load(1'b0);
      for (int p = 0; p < 16; p++) begin
         beat(3'b101, 1'b0);
         if (p != 15) idle(1);
      end
      idle(2);

      // Abort on the 6th beat, then a fresh load from page 0.
      load_abort = 1'b1;           // abort in IDLE has no effect
      step();
      load_abort = 1'b0;
      start_load(1'b1);
      for (int p = 0; p < 5; p++) beat(3'($urandom_range(0, 7)), 1'b0);
      beat(3'b111, 1'b1);
      idle(2);
      start_load(1'b1);
      for (int p = 0; p < 16; p++) beat(3'($urandom_range(0, 7)), 1'b0);
      idle(1);

      // Same-cycle start+abort with a beat while loading: abort wins, error set.
      start_load(1'b0);
      for (int p = 0; p < 3; p++) beat(3'($urandom_range(0, 7)), 1'b0);
      bad_start(1'b1);
      idle(2);

      // load_start at page 7: error, load continues to completion.
      start_load(1'b0);
      for (int p = 0; p < 7; p++) beat(3'($urandom_range(0, 7)), 1'b0);
      bad_start(1'b0);
      for (int p = 7; p < 16; p++) beat(3'($urandom_range(0, 7)), 1'b0);
      idle(2);

      // Checksum pattern: fifteen 3'b011 then 3'b100 -> 3'b111.
      start_load(1'b1);
      for (int p = 0; p < 15; p++) beat(3'b011, 1'b0);
      beat(3'b100, 1'b0);
      idle(2);

      // Random loads with random gaps.
      for (int l = 0; l < 4; l++) begin
         start_load(1'($urandom_range(0, 1)));
         for (int p = 0; p < 16; p++) begin
            beat(3'($urandom), 1'b0);
            if (p != 15) idle($urandom_range(0, 2));
         end
         idle($urandom_range(1, 3));
      end

      // Reset in the middle of a write: write enable drops at once.
      start_load(1'b0);
      for (int p = 0; p < 3; p++) beat(3'($urandom_range(0, 7)), 1'b0);
      lut_valid_in = 1'b1;
      lut_data_in  = 3'b010;
      step();                      // this beat's write is cut by reset
      lut_valid_in = 1'b0;
      chk("we_before_reset", 32'(ib_ram_we), 32'd1);
      rstn   = 1'b0;
      m_busy = 1'b0;
      m_err  = 1'b0;
      m_page = 0;
      #1;
      chk("we_async_drop", 32'(ib_ram_we), 32'd0);
      chk("err_cleared", 32'(loader_err), 32'd0);
      chk("addr_after_reset", 32'(page_addr_ram_replicate_0), 32'd0);
      repeat (2) step();
      rstn = 1'b1;
      step();

      // Recovery load after reset.
      start_load(1'b1);
      for (int p = 0; p < 16; p++) beat(3'($urandom), 1'b0);
      idle(3);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Safety net against a runaway simulation.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
